// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: size codes, FSM states, lane helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mem_pkg;

  // Access size encoding carried down the pipe from decode
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // MEM-stage FSM states
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Request fields latched when an access starts
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [1:0]  size;
    logic        uns;
    logic        mem_to_reg;
    logic        reg_write;
    logic        we;
  } req_t;

  // Byte enables; half uses only lane[1], word ignores the lane (natural alignment)
  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: store_be = 4'b0001 << lane;
      SZ_HALF: store_be = lane[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Store data replicated across lanes so the byte enables pick the right copy
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: store_data = {4{wdata[7:0]}};
      SZ_HALF: store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select with sign/zero extension of the returned memory word.
// Latency: purely combinational.
// Backpressure: none; result follows the inputs.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        load_unsigned,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half, then extend to 32 bits
  always_comb begin
    byte_sel = 8'h00;
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    case (lane)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    case (size)
      SZ_BYTE: data = {{24{byte_sel[7] & ~load_unsigned}}, byte_sel};
      SZ_HALF: data = {{16{half_sel[15] & ~load_unsigned}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: issues data-memory loads/stores and stalls the pipe until ack or timeout.
// Latency: non-memory ops pass through combinationally; memory ops take IDLE+WAIT(n)+DONE.
// Backpressure: stall holds upstream while waiting; MEM_MISALIGN_TRAP_EN adds the misalign trap port.
module mem_access
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_to_reg,
  input  logic        reg_write,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic [4:0]  rd_num,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] alu_result_out,
  output logic [31:0] read_data_out,
  output logic [4:0]  rd_num_out,
  output logic        mem_to_reg_out,
  output logic        reg_write_out,
  output logic        valid_out,
  output logic        stall,
  output logic        bus_err
`ifdef MEM_MISALIGN_TRAP_EN
  ,output logic       misalign
`endif
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  req_t          req_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [31:0]   ld_data;
  logic          mem_op;
  logic          mis_trap;
  logic          start;

  assign mem_op = valid & (mem_read | mem_write);

`ifdef MEM_MISALIGN_TRAP_EN
  // Misaligned half/word accesses never reach memory; the op falls through unretired
  assign mis_trap = mem_op & (((size == SZ_HALF) & alu_result[0]) |
                              (size[1] & (alu_result[1:0] != 2'b00)));
  assign misalign = mis_trap;
`else
  assign mis_trap = 1'b0;
`endif

  assign start = mem_op & ~mis_trap;

  load_align u_load_align (
    .rdata         (dmem_rdata),
    .size          (req_q.size),
    .lane          (req_q.addr[1:0]),
    .load_unsigned (req_q.uns),
    .data          (ld_data)
  );

  // Access FSM: latch request, wait for ack or timeout, present result for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (start) begin
            req_q.addr       <= alu_result;
            req_q.wdata      <= write_data;
            req_q.rd         <= rd_num;
            req_q.size       <= size;
            req_q.uns        <= load_unsigned;
            req_q.mem_to_reg <= mem_to_reg;
            req_q.reg_write  <= reg_write;
            req_q.we         <= mem_write;
            err_q            <= 1'b0;
            state            <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dmem_ack) begin
            rdata_q <= ld_data;
            state   <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            bus_err <= 1'b1;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Request drive comes only from latched fields, so it is stable across WAIT
  always_comb begin
    dmem_req   = (state == ST_WAIT);
    dmem_we    = req_q.we;
    dmem_addr  = {req_q.addr[31:2], 2'b00};
    dmem_be    = store_be(req_q.size, req_q.addr[1:0]);
    dmem_wdata = store_data(req_q.size, req_q.wdata);
  end

  // MEM/WB feed: pass-through when idle, bubble while stalled, latched result in DONE
  always_comb begin
    alu_result_out = alu_result;
    rd_num_out     = rd_num;
    mem_to_reg_out = mem_to_reg;
    reg_write_out  = reg_write & ~mis_trap;
    valid_out      = valid;
    read_data_out  = '0;
    stall          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          stall         = 1'b1;
          valid_out     = 1'b0;
          reg_write_out = 1'b0;
        end
      end
      ST_WAIT: begin
        stall         = 1'b1;
        valid_out     = 1'b0;
        reg_write_out = 1'b0;
      end
      ST_DONE: begin
        alu_result_out = req_q.addr;
        rd_num_out     = req_q.rd;
        mem_to_reg_out = req_q.mem_to_reg;
        reg_write_out  = req_q.reg_write & ~err_q;
        valid_out      = 1'b1;
        read_data_out  = rdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a 4-cycle timeout.
// Latency: drives on posedge+1, samples on posedge+2.
// Backpressure: follows stall to find the DONE cycle.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, mem_read, mem_write, mem_to_reg, reg_write;
  logic [31:0] alu_result, write_data;
  logic [4:0]  rd_num;
  logic [1:0]  size;
  logic        load_unsigned;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] alu_result_out, read_data_out;
  logic [4:0]  rd_num_out;
  logic        mem_to_reg_out, reg_write_out, valid_out, stall, bus_err;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int tests = 0;
  int fails = 0;
  int stall_cyc = 0;
  int berr_cyc = 0;
  int base_s, base_b;

  logic [31:0] cap_addr, cap_wdata, cap_rdo;
  logic [3:0]  cap_be;
  logic        cap_we, cap_req, cap_rw, cap_vo;
  logic [4:0]  cap_rd;
  int          cap_waits;

  mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .valid(valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_result(alu_result),
    .write_data(write_data), .rd_num(rd_num), .size(size), .load_unsigned(load_unsigned),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .alu_result_out(alu_result_out), .read_data_out(read_data_out), .rd_num_out(rd_num_out),
    .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out), .valid_out(valid_out),
    .stall(stall), .bus_err(bus_err)
`ifdef MEM_MISALIGN_TRAP_EN
    ,.misalign(misalign)
`endif
  );

  always #5 clk = ~clk;

  // Cycle-level tallies of stall and bus_err, sampled mid-cycle
  always @(negedge clk) begin
    if (stall === 1'b1) stall_cyc++;
    if (bus_err === 1'b1) berr_cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    valid = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0; reg_write = 0;
    alu_result = 0; write_data = 0; rd_num = 0; size = 0; load_unsigned = 0;
  endtask

  // One full access; ack_at is the WAIT cycle (1-based) carrying ack, 0 for none
  task automatic run_access(input logic rd_i, input logic wr_i, input logic [1:0] sz,
                            input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rdat, input int ack_at);
    int n;
    valid = 1; mem_read = rd_i; mem_write = wr_i; mem_to_reg = rd_i; reg_write = rd_i;
    size = sz; load_unsigned = uns; alu_result = addr; write_data = wd; rd_num = 5'd9;
    @(posedge clk); #1;
    cap_addr = dmem_addr; cap_wdata = dmem_wdata; cap_be = dmem_be;
    cap_we = dmem_we; cap_req = dmem_req;
    n = 1;
    while (stall === 1'b1 && n <= 20) begin
      if (n == ack_at) begin
        dmem_ack = 1; dmem_rdata = rdat;
      end
      @(posedge clk); #1;
      dmem_ack = 0; dmem_rdata = 32'h0BAD_F00D;
      n++;
    end
    cap_waits = n - 1;
    cap_rdo = read_data_out; cap_rw = reg_write_out; cap_vo = valid_out; cap_rd = rd_num_out;
    chk("done_stall_low", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    rst = 1; dmem_ack = 0; dmem_rdata = 32'h0BAD_F00D;
    idle_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_valid_out", {31'b0, valid_out}, 32'd0);
    chk("rst_read_data", read_data_out, 32'd0);
    rst = 0;
    @(posedge clk); #1;

    // Non-memory op passes straight through
    valid = 1; reg_write = 1; alu_result = 32'h0000_1234; rd_num = 5'd5;
    #1;
    chk("pt_alu", alu_result_out, 32'h0000_1234);
    chk("pt_rd", {27'b0, rd_num_out}, 32'd5);
    chk("pt_valid", {31'b0, valid_out}, 32'd1);
    chk("pt_rw", {31'b0, reg_write_out}, 32'd1);
    chk("pt_stall", {31'b0, stall}, 32'd0);
    chk("pt_rdata", read_data_out, 32'd0);
    chk("pt_req", {31'b0, dmem_req}, 32'd0);

    // Ack while idle must not start or complete anything
    @(posedge clk); #1;
    idle_inputs(); dmem_ack = 1; dmem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    dmem_ack = 0;
    chk("idle_ack_req", {31'b0, dmem_req}, 32'd0);
    chk("idle_ack_valid", {31'b0, valid_out}, 32'd0);
    chk("idle_ack_rdata", read_data_out, 32'd0);
    @(posedge clk); #1;

    // lw 0x100, ack on third WAIT cycle
    base_s = stall_cyc; base_b = berr_cyc;
    run_access(1, 0, 2'b10, 0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3);
    chk("lw_req", {31'b0, cap_req}, 32'd1);
    chk("lw_addr", cap_addr, 32'h0000_0100);
    chk("lw_we", {31'b0, cap_we}, 32'd0);
    chk("lw_waits", cap_waits, 32'd3);
    chk("lw_rdata", cap_rdo, 32'hDEAD_BEEF);
    chk("lw_valid", {31'b0, cap_vo}, 32'd1);
    chk("lw_rw", {31'b0, cap_rw}, 32'd1);
    chk("lw_rd", {27'b0, cap_rd}, 32'd9);
    chk("lw_stall_cycles", stall_cyc - base_s, 32'd4);
    chk("lw_no_berr", berr_cyc - base_b, 32'd0);

    // Byte and half loads, signed and unsigned
    run_access(1, 0, 2'b00, 0, 32'h0000_0103, 32'h0, 32'h8011_2233, 1);
    chk("lb_signed", cap_rdo, 32'hFFFF_FF80);
    run_access(1, 0, 2'b00, 1, 32'h0000_0103, 32'h0, 32'h8011_2233, 1);
    chk("lbu", cap_rdo, 32'h0000_0080);
    run_access(1, 0, 2'b01, 0, 32'h0000_0102, 32'h0, 32'h8001_1234, 2);
    chk("lh_signed", cap_rdo, 32'hFFFF_8001);
    run_access(1, 0, 2'b01, 1, 32'h0000_0102, 32'h0, 32'h8001_1234, 2);
    chk("lhu", cap_rdo, 32'h0000_8001);

    // Stores
    run_access(0, 1, 2'b01, 0, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 1);
    chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    chk("sh_be", {28'b0, cap_be}, 32'hC);
    chk("sh_we", {31'b0, cap_we}, 32'd1);
    chk("sh_addr", cap_addr, 32'h0000_0200);
    run_access(0, 1, 2'b00, 0, 32'h0000_0101, 32'h0000_00A5, 32'h0, 1);
    chk("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
    chk("sb_be", {28'b0, cap_be}, 32'h2);
    run_access(1, 1, 2'b10, 0, 32'h0000_0300, 32'h1234_5678, 32'h0, 1);
    chk("rw_both_we", {31'b0, cap_we}, 32'd1);
    chk("sw_be", {28'b0, cap_be}, 32'hF);
    chk("sw_wdata", cap_wdata, 32'h1234_5678);

    // Timeout: no ack for 4 WAIT cycles
    base_b = berr_cyc;
    run_access(1, 0, 2'b10, 0, 32'h0000_0400, 32'h0, 32'h0, 0);
    chk("to_waits", cap_waits, 32'd4);
    chk("to_berr_pulse", berr_cyc - base_b, 32'd1);
    chk("to_rdata", cap_rdo, 32'd0);
    chk("to_rw", {31'b0, cap_rw}, 32'd0);
    chk("to_valid", {31'b0, cap_vo}, 32'd1);

`ifndef MEM_MISALIGN_TRAP_EN
    // Misaligned accesses are aligned down to the natural boundary
    run_access(1, 0, 2'b10, 0, 32'h0000_0102, 32'h0, 32'hCAFE_F00D, 1);
    chk("mis_lw_addr", cap_addr, 32'h0000_0100);
    chk("mis_lw_data", cap_rdo, 32'hCAFE_F00D);
    run_access(0, 1, 2'b01, 0, 32'h0000_0203, 32'h0000_1357, 32'h0, 1);
    chk("mis_sh_be", {28'b0, cap_be}, 32'hC);
`endif

    // Reset in the second WAIT cycle, late ack afterwards
    valid = 1; mem_read = 1; reg_write = 1; mem_to_reg = 1; size = 2'b10;
    alu_result = 32'h0000_0500; rd_num = 5'd3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; idle_inputs(); dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rstw_req", {31'b0, dmem_req}, 32'd0);
    chk("rstw_stall", {31'b0, stall}, 32'd0);
    chk("rstw_valid", {31'b0, valid_out}, 32'd0);
    @(posedge clk); #1;
    dmem_ack = 0;
    chk("rstw_req2", {31'b0, dmem_req}, 32'd0);
    chk("rstw_valid2", {31'b0, valid_out}, 32'd0);
    chk("rstw_rdata2", read_data_out, 32'd0);
    chk("rstw_berr2", {31'b0, bus_err}, 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
    // Misaligned word load traps with no memory request
    @(posedge clk); #1;
    valid = 1; mem_read = 1; reg_write = 1; size = 2'b10; alu_result = 32'h0000_0101;
    #1;
    chk("trap_misalign", {31'b0, misalign}, 32'd1);
    chk("trap_req", {31'b0, dmem_req}, 32'd0);
    chk("trap_stall", {31'b0, stall}, 32'd0);
    chk("trap_rw", {31'b0, reg_write_out}, 32'd0);
    chk("trap_valid", {31'b0, valid_out}, 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    #1;
    chk("trap_req_after", {31'b0, dmem_req}, 32'd0);
    chk("trap_misalign_after", {31'b0, misalign}, 32'd0);
`endif

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles WAIT may last before the access is abandoned.
REQ-002 One clock, clk; reset is synchronous and active-high, rst.
REQ-003 clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-004 valid, mem_read, mem_write, mem_to_reg, reg_write  in  1 each  EX/MEM control fields.
REQ-005 alu_result  in  32  effective address or ALU value; write_data  in  32  store data; rd_num  in  5  destination register.
REQ-006 size  in  2  access size (00 byte, 01 half, 10 word); load_unsigned  in  1  zero-extend loads.
REQ-007 dmem_req, dmem_we  out  1; dmem_addr  out  32; dmem_wdata  out  32; dmem_be  out  4  data-memory request.
REQ-008 dmem_ack  in  1  one-cycle completion pulse; dmem_rdata  in  32  read word, valid with dmem_ack.
REQ-009 alu_result_out, read_data_out  out  32; rd_num_out  out  5; mem_to_reg_out, reg_write_out, valid_out  out  1  feed the MEM/WB register.
REQ-010 stall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM; bus_err  out  1  timeout pulse.

Function
REQ-011 FSM states IDLE, WAIT, DONE; a memory op is valid && (mem_read || mem_write).
REQ-012 IDLE, no memory op: outputs pass inputs through combinationally, read_data_out=0, stall=0, zero added latency.
REQ-013 IDLE, memory op: stall=1, register request fields, go to WAIT.
REQ-014 WAIT: dmem_req=1 with stable addr/we/wdata/be, stall=1; on dmem_ack capture extended data, go to DONE.
REQ-015 WAIT: counter increments each cycle; on reaching TIMEOUT_CYCLES without ack, bus_err pulses one cycle, captured data=0, reg_write_out forced 0 in DONE, go to DONE.
REQ-016 DONE: stall=0, valid_out=1, read_data_out=captured data, other outputs from the held EX/MEM inputs; go to IDLE next cycle.
REQ-017 dmem_ack in IDLE or DONE is ignored.
REQ-018 dmem_addr = {alu_result[31:2],2'b00}; lane = alu_result[1:0].
REQ-019 Store: byte replicated to all lanes, be=1<<lane; half replicated to both halves, be=0011 or 1100 by lane[1]; word be=1111.
REQ-020 Load: select lane byte/half, sign-extend unless load_unsigned; word unmodified.
REQ-021 Upstream holds EX/MEM inputs stable while stall=1; the block relies on this.
REQ-022 mem_read && mem_write both set: treated as store.

Reset
REQ-023 rst=1: state IDLE, counter 0, dmem_req 0, bus_err 0, captured data 0, all registered outputs 0.
REQ-024 Reset in WAIT: dmem_req drops the cycle after the reset edge; a late dmem_ack is ignored.

Configuration
REQ-025 Macro MEM_MISALIGN_TRAP_EN.
REQ-026 Defined: half with lane[0]=1 or word with lane!=0 issues no request, asserts out-port misalign (1 bit) for one cycle, passes through with reg_write_out=0, stall=0.
REQ-027 Undefined: no misalign port; low bits ignored, access aligned down to natural boundary.

Structure
REQ-028 Shared package mem_pkg: size encoding constants, FSM state enum, lane/byte-enable helper functions.
REQ-029 One sub-module load_align: combinational lane select and sign/zero extension.

Verification
REQ-030 lw addr 0x100, ack after 3 cycles, rdata 0xDEADBEEF -> stall high 4 cycles, DONE read_data_out=0xDEADBEEF, valid_out=1.
REQ-031 lb addr 0x103, rdata 0x80112233, signed -> 0xFFFFFF80; load_unsigned -> 0x00000080.
REQ-032 sh addr 0x202, write_data 0x0000ABCD -> dmem_wdata=0xABCDABCD, be=1100, dmem_we=1.
REQ-033 No ack for TIMEOUT_CYCLES=4 -> bus_err pulse after 4 WAIT cycles, read_data_out=0, reg_write_out=0.
REQ-034 rst asserted in second WAIT cycle, ack one cycle later -> state IDLE, dmem_req 0, ack ignored, outputs 0.
REQ-035 With MEM_MISALIGN_TRAP_EN, lw addr 0x101 -> no dmem_req, misalign=1, reg_write_out=0, stall=0.
